// File: rtl/cdb_arbiter.sv
// Producer side of the common data bus: one result slot per functional unit,
// round-robin (or fixed-priority) selection, one registered broadcast per cycle.
module cdb_arbiter #(
   parameter int NUM_SRC = 3,
   parameter int RR_EN   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [NUM_SRC-1:0]    src_valid,
   input  logic [NUM_SRC*16-1:0] src_data,
   input  logic [NUM_SRC*3-1:0]  src_tag,
   output logic [NUM_SRC-1:0]    src_ready,
   output logic [19:0]           cdb_out,
   output logic                  busy
);

   localparam int          PW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [PW:0] NSRC = (PW+1)'(NUM_SRC);
   localparam logic [PW-1:0] LAST = PW'(NUM_SRC - 1);

   logic          r_full [NUM_SRC];
   logic [15:0]   r_data [NUM_SRC];
   logic [2:0]    r_tag  [NUM_SRC];
   logic [PW-1:0] r_rr_ptr;
   logic [19:0]   r_cdb;

   logic               w_gnt_any;
   logic [PW-1:0]      w_gnt_idx;
   logic [PW-1:0]      w_base;
   logic [PW:0]        w_scan;
   logic [PW-1:0]      w_next_ptr;
   logic [NUM_SRC-1:0] w_gnt;
   logic [NUM_SRC-1:0] w_accept;
   logic               w_busy;

   // Scan slots starting at the base index, wrapping; first full slot wins.
   always_comb begin
      w_base    = (RR_EN != 0) ? r_rr_ptr : '0;
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      w_scan    = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_scan = {1'b0, w_base} + (PW+1)'(k);
         if (w_scan >= NSRC) begin
            w_scan = w_scan - NSRC;
         end
         if (!w_gnt_any && r_full[w_scan[PW-1:0]]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = w_scan[PW-1:0];
         end
      end
   end

   assign w_next_ptr = (w_gnt_idx == LAST) ? '0 : w_gnt_idx + 1'b1;

   always_comb begin
      w_busy = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_busy = w_busy | r_full[k];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_slot
         assign w_gnt[gi]     = w_gnt_any && (w_gnt_idx == PW'(gi));
         // A slot being drained this cycle can be refilled at the same edge.
         assign src_ready[gi] = !flush && (!r_full[gi] || w_gnt[gi]);
         assign w_accept[gi]  = src_valid[gi] && src_ready[gi];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_full[gi] <= 1'b0;
               r_data[gi] <= '0;
               r_tag[gi]  <= '0;
            end else if (flush) begin
               r_full[gi] <= 1'b0;
            end else if (w_accept[gi]) begin
               r_full[gi] <= 1'b1;
               r_data[gi] <= src_data[gi*16 +: 16];
               r_tag[gi]  <= src_tag[gi*3 +: 3];
            end else if (w_gnt[gi]) begin
               r_full[gi] <= 1'b0;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cdb    <= '0;
         r_rr_ptr <= '0;
      end else if (flush) begin
         r_cdb[19] <= 1'b0;
         r_rr_ptr  <= '0;
      end else if (w_gnt_any) begin
         r_cdb    <= {1'b1, r_data[w_gnt_idx], r_tag[w_gnt_idx]};
         r_rr_ptr <= w_next_ptr;
      end else begin
         r_cdb[19] <= 1'b0;
      end
   end

   assign cdb_out = r_cdb;
   assign busy    = w_busy;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, hand sequences
// for streaming and fixed priority, and random traffic against a slot model.
module tb_cdb_arbiter;

   localparam int N = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush = 1'b0;
   logic [N-1:0]    src_valid = '0;
   logic [N*16-1:0] src_data = '0;
   logic [N*3-1:0]  src_tag = '0;
   logic [N-1:0]    rdy_rr, rdy_fp;
   logic [19:0]     cdb_rr, cdb_fp;
   logic            busy_rr, busy_fp;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cdb_arbiter #(.NUM_SRC(N), .RR_EN(1)) dut_rr (
      .clk(clk), .rst_n(rst_n), .flush(flush), .src_valid(src_valid),
      .src_data(src_data), .src_tag(src_tag), .src_ready(rdy_rr),
      .cdb_out(cdb_rr), .busy(busy_rr));

   cdb_arbiter #(.NUM_SRC(N), .RR_EN(0)) dut_fp (
      .clk(clk), .rst_n(rst_n), .flush(flush), .src_valid(src_valid),
      .src_data(src_data), .src_tag(src_tag), .src_ready(rdy_fp),
      .cdb_out(cdb_fp), .busy(busy_fp));

   typedef struct {
      logic        fl;
      logic [2:0]  v;
      logic [15:0] d0, d1, d2;
      logic [2:0]  t0, t1, t2;
      logic [2:0]  er;
      logic        ev;
      logic [15:0] ed;
      logic [2:0]  et;
      logic        eb;
   } vec_t;

   vec_t vt [14];

   // reference model state (round-robin instance)
   bit          m_full [N];
   logic [15:0] m_data [N];
   logic [2:0]  m_tag  [N];
   int          m_ptr;
   logic [19:0] m_cdb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // data/tag are don't-care while valid is low
   task automatic chk_cdb(input string name, input logic [19:0] act, input logic ev,
                          input logic [15:0] ed, input logic [2:0] et);
      if (ev) chk(name, 32'(act), 32'({1'b1, ed, et}));
      else    chk({name, "_v"}, 32'(act[19]), 32'd0);
   endtask

   task automatic set_src(input int i, input logic v, input logic [15:0] d, input logic [2:0] t);
      src_valid[i]       = v;
      src_data[i*16 +: 16] = d;
      src_tag[i*3 +: 3]    = t;
   endtask

   function automatic int m_grant();
      for (int k = 0; k < N; k++) begin
         if (m_full[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < N; i++) m_full[i] = 0;
      m_ptr = 0;
      m_cdb = '0;
   endtask

   initial begin
      logic [N-1:0] exp_rdy;
      logic [N-1:0] pend;
      logic [15:0]  pd [N];
      logic [2:0]   pt [N];
      int           g;

      vt = '{
         '{1'b0, 3'b001, 16'h1234, 16'h0, 16'h0, 3'd5, 3'd0, 3'd0, 3'b111, 1'b0, 16'h0,    3'd0, 1'b1},
         '{1'b0, 3'b000, 16'h0,    16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'b111, 1'b1, 16'h1234, 3'd5, 1'b0},
         '{1'b0, 3'b000, 16'h0,    16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'b111, 1'b0, 16'h0,    3'd0, 1'b0},
         '{1'b1, 3'b000, 16'h0,    16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 16'h0,    3'd0, 1'b0},
         '{1'b0, 3'b111, 16'h00A1, 16'h00A2, 16'h00A3, 3'd1, 3'd2, 3'd3, 3'b111, 1'b0, 16'h0, 3'd0, 1'b1},
         '{1'b0, 3'b000, 16'h0,    16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'b001, 1'b1, 16'h00A1, 3'd1, 1'b1},
         '{1'b0, 3'b000, 16'h0,    16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'b011, 1'b1, 16'h00A2, 3'd2, 1'b1},
         '{1'b0, 3'b000, 16'h0,    16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'b111, 1'b1, 16'h00A3, 3'd3, 1'b0},
         '{1'b0, 3'b000, 16'h0,    16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'b111, 1'b0, 16'h0,    3'd0, 1'b0},
         '{1'b0, 3'b111, 16'h00B1, 16'h00B2, 16'h00B3, 3'd4, 3'd5, 3'd6, 3'b111, 1'b0, 16'h0, 3'd0, 1'b1},
         '{1'b1, 3'b100, 16'h0,    16'h0, 16'h00B4, 3'd0, 3'd0, 3'd7, 3'b000, 1'b0, 16'h0,  3'd0, 1'b0},
         '{1'b0, 3'b001, 16'h00C0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'b111, 1'b0, 16'h0,    3'd0, 1'b1},
         '{1'b0, 3'b000, 16'h0,    16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'b111, 1'b1, 16'h00C0, 3'd0, 1'b0},
         '{1'b0, 3'b000, 16'h0,    16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'b111, 1'b0, 16'h0,    3'd0, 1'b0}
      };

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_cdb", 32'(cdb_rr), 32'd0);
      chk("reset_ready", 32'(rdy_rr), 32'(3'b111));
      chk("reset_busy", 32'(busy_rr), 32'd0);
      chk("reset_cdb_fp", 32'(cdb_fp), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk("idle_valid", 32'(cdb_rr[19]), 32'd0);
      end

      // directed vectors: single result, round-robin contention, flush
      for (int r = 0; r < 14; r++) begin
         flush = vt[r].fl;
         set_src(0, vt[r].v[0], vt[r].d0, vt[r].t0);
         set_src(1, vt[r].v[1], vt[r].d1, vt[r].t1);
         set_src(2, vt[r].v[2], vt[r].d2, vt[r].t2);
         #1;
         chk($sformatf("vec%0d_ready", r), 32'(rdy_rr), 32'(vt[r].er));
         @(posedge clk);
         #1;
         chk_cdb($sformatf("vec%0d_cdb", r), cdb_rr, vt[r].ev, vt[r].ed, vt[r].et);
         chk($sformatf("vec%0d_busy", r), 32'(busy_rr), 32'(vt[r].eb));
         $display("[TB] vec %0d flush=%0b valid=%b cdb=%h busy=%0b", r, vt[r].fl, vt[r].v, cdb_rr, busy_rr);
      end
      flush = 1'b0;

      // streaming on src1: ten back-to-back results
      for (int c = 0; c < 12; c++) begin
         set_src(1, c < 10, 16'(c), 3'd2);
         #1;
         if (c < 10) chk("stream_ready", 32'(rdy_rr[1]), 32'd1);
         @(posedge clk);
         #1;
         chk_cdb("stream_cdb", cdb_rr, (c >= 1) && (c <= 10), 16'(c - 1), 3'd2);
         $display("[TB] stream %0d cdb=%h", c, cdb_rr);
      end

      // fixed priority: src0 streams, src2 waits until src0 stops
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         set_src(0, c <= 5, 16'h0F00 + 16'(c), 3'd0);
         set_src(2, c == 0, 16'h2222, 3'd6);
         #1;
         if (c <= 5) chk("fp_ready0", 32'(rdy_fp[0]), 32'd1);
         if (c >= 1 && c <= 6) chk("fp_ready2_wait", 32'(rdy_fp[2]), 32'd0);
         if (c == 7) chk("fp_ready2_grant", 32'(rdy_fp[2]), 32'd1);
         @(posedge clk);
         #1;
         if (c == 7) chk_cdb("fp_cdb", cdb_fp, 1'b1, 16'h2222, 3'd6);
         else chk_cdb("fp_cdb", cdb_fp, (c >= 1) && (c <= 6), 16'h0F00 + 16'(c - 1), 3'd0);
         $display("[TB] fixprio %0d cdb=%h", c, cdb_fp);
      end
      chk("fp_busy_end", 32'(busy_fp), 32'd0);

      // random traffic against the model
      src_valid = '0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      m_reset();
      pend = '0;
      for (int it = 0; it < 600; it++) begin
         if ($urandom_range(99) == 0) begin
            rst_n = 1'b0;
            flush = 1'b0;
            src_valid = '0;
            pend = '0;
            #1;
            m_reset();
            chk("rnd_rst_cdb", 32'(cdb_rr), 32'd0);
            chk("rnd_rst_busy", 32'(busy_rr), 32'd0);
            chk("rnd_rst_ready", 32'(rdy_rr), 32'(3'b111));
            @(posedge clk);
            #1;
            chk("rnd_rst_hold", 32'(cdb_rr), 32'd0);
            rst_n = 1'b1;
         end else begin
            flush = ($urandom_range(19) == 0);
            for (int i = 0; i < N; i++) begin
               if (!pend[i] && $urandom_range(1) == 1) begin
                  pend[i] = 1'b1;
                  pd[i] = 16'($urandom);
                  pt[i] = 3'($urandom);
               end
               set_src(i, pend[i], pend[i] ? pd[i] : 16'h0, pend[i] ? pt[i] : 3'd0);
            end
            #1;
            g = m_grant();
            for (int i = 0; i < N; i++) exp_rdy[i] = !flush && (!m_full[i] || g == i);
            chk("rnd_ready", 32'(rdy_rr), 32'(exp_rdy));
            @(posedge clk);
            #1;
            if (flush) begin
               for (int i = 0; i < N; i++) m_full[i] = 0;
               m_cdb[19] = 1'b0;
               m_ptr = 0;
            end else begin
               if (g >= 0) begin
                  m_cdb = {1'b1, m_data[g], m_tag[g]};
                  m_ptr = (g + 1) % N;
               end else begin
                  m_cdb[19] = 1'b0;
               end
               for (int i = 0; i < N; i++) begin
                  if (pend[i] && exp_rdy[i]) begin
                     m_full[i] = 1;
                     m_data[i] = pd[i];
                     m_tag[i]  = pt[i];
                     pend[i]   = 1'b0;
                  end else if (g == i) begin
                     m_full[i] = 0;
                  end
               end
            end
            chk_cdb("rnd_cdb", cdb_rr, m_cdb[19], m_cdb[18:3], m_cdb[2:0]);
            chk("rnd_busy", 32'(busy_rr), 32'(m_full[0] | m_full[1] | m_full[2]));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
